// File: rtl/i2c_write_sequencer.sv
// Register-write command sequencer driving a bit-level I2C master engine:
// START, address byte, register byte, 1-4 data bytes, STOP, with NACK retry.
module i2c_write_sequencer #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 1000,
  parameter logic        RW_BIT    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_dev,
  input  logic [7:0]  cmd_reg,
  input  logic [1:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        eng_req,
  output logic [1:0]  eng_op,
  output logic [7:0]  eng_wdata,
  input  logic        eng_done,
  input  logic        eng_nack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  retry_cnt
);

  localparam int unsigned GAP_W = $clog2(RETRY_GAP) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (RETRY_GAP > 0) ? GAP_W'(RETRY_GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_REG, S_DATA, S_STOP, S_GAP, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [1:0]       len_q, len_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       idx_q, idx_d;
  logic             abort_q, abort_d;
  logic [1:0]       retry_q, retry_d;
  logic             error_q, error_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             req_q, req_d;
  logic [7:0]       data_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dev_q   <= '0;
      reg_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      abort_q <= 1'b0;
      retry_q <= '0;
      error_q <= 1'b0;
      gap_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      len_q   <= len_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      abort_q <= abort_d;
      retry_q <= retry_d;
      error_q <= error_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    data_byte = data_q[7:0];
      2'd1:    data_byte = data_q[15:8];
      2'd2:    data_byte = data_q[23:16];
      default: data_byte = data_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    len_d   = len_q;
    data_d  = data_q;
    idx_d   = idx_q;
    abort_d = abort_q;
    retry_d = retry_q;
    error_d = error_q;
    gap_d   = gap_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          len_d   = cmd_len;
          data_d  = cmd_data;
          idx_d   = '0;
          abort_d = 1'b0;
          retry_d = '0;
          error_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START, S_ADDR, S_REG, S_DATA, S_STOP: begin
        // Request rises one cycle after entering an op state, giving the
        // mandatory one-cycle low gap; eng_done is only honoured while req is up.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (eng_done) begin
          req_d = 1'b0;
          case (state_q)
            S_START: state_d = S_ADDR;
            S_ADDR: begin
              if (eng_nack) begin
                abort_d = 1'b1;
                state_d = S_STOP;
              end else begin
                state_d = S_REG;
              end
            end
            S_REG: begin
              if (eng_nack) begin
                abort_d = 1'b1;
                state_d = S_STOP;
              end else begin
                state_d = S_DATA;
              end
            end
            S_DATA: begin
              if (eng_nack) begin
                abort_d = 1'b1;
                state_d = S_STOP;
              end else if (idx_q == len_q) begin
                state_d = S_STOP;
              end else begin
                idx_d = idx_q + 2'd1;
              end
            end
            S_STOP: begin
              if (!abort_q) begin
                error_d = 1'b0;
                state_d = S_FINISH;
              end else if ({30'd0, retry_q} < MAX_RETRY) begin
                gap_d   = GAP_LOAD;
                state_d = S_GAP;
              end else begin
                error_d = 1'b1;
                state_d = S_FINISH;
              end
            end
            default: ;
          endcase
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          retry_d = retry_q + 2'd1;
          idx_d   = '0;
          abort_d = 1'b0;
          state_d = S_START;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_op    = 2'd0;
    eng_wdata = '0;
    case (state_q)
      S_ADDR: begin
        eng_op    = 2'd1;
        eng_wdata = {dev_q, RW_BIT};
      end
      S_REG: begin
        eng_op    = 2'd1;
        eng_wdata = reg_q;
      end
      S_DATA: begin
        eng_op    = 2'd1;
        eng_wdata = data_byte;
      end
      S_STOP:  eng_op = 2'd2;
      default: ;
    endcase
  end

  assign eng_req   = req_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign error     = error_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer with a scripted engine responder
// that logs every request and can NACK, delay and inject stray eng_done.
module tb_i2c_write_sequencer;

  localparam int unsigned MAXR = 3;
  localparam int unsigned RG   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg;
  logic [1:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        eng_req;
  logic [1:0]  eng_op;
  logic [7:0]  eng_wdata;
  logic        eng_done;
  logic        eng_nack;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  retry_cnt;

  always #5 clk = ~clk;

  i2c_write_sequencer #(.MAX_RETRY(MAXR), .RETRY_GAP(RG), .RW_BIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .eng_req(eng_req), .eng_op(eng_op), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_nack(eng_nack),
    .busy(busy), .done(done), .error(error), .retry_cnt(retry_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine configuration (written by the main process only)
  int nack_mode = 0;
  int nack_cap  = 0;
  int fixed_dly = 2;
  bit rand_dly  = 1'b0;
  bit spur_ext  = 1'b0;
  int idle_spur_req = 0;

  // Engine model state and request log (written by the engine process only)
  logic [1:0] op_log [256];
  logic [7:0] wd_log [256];
  int         gap_log[256];
  int n_log = 0;
  int stab_err = 0;
  int nack_given = 0;
  int idle_spur_done = 0;
  bit active = 1'b0;
  int hold = 0;
  int wait_cnt = 0;
  int lowcnt = 0;
  int wcount = 0;
  logic [1:0] cur_op;
  logic [7:0] cur_wd;

  task fire();
    logic n;
    n = 1'b0;
    if (cur_op == 2'd1) begin
      if (nack_mode == 1 && wcount == 1 && nack_given < nack_cap) n = 1'b1;
      if (nack_mode == 2 && wcount == 4) n = 1'b1;
    end
    if (n) nack_given++;
    eng_done = 1'b1;
    eng_nack = n;
    hold     = spur_ext ? 2 : 1;
    active   = 1'b0;
    lowcnt   = 0;
  endtask

  initial begin
    eng_done = 1'b0;
    eng_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 1'b0; hold = 0; lowcnt = 0;
        eng_done = 1'b0; eng_nack = 1'b0;
      end else begin
        if (hold > 0) begin
          hold--;
          eng_nack = 1'b0;
          if (hold == 0) eng_done = 1'b0;
        end
        if (active) begin
          if (eng_req !== 1'b1 || eng_op !== cur_op || eng_wdata !== cur_wd) stab_err++;
          wait_cnt--;
          if (wait_cnt <= 0) fire();
        end else if (eng_req === 1'b1 && hold == 0) begin
          cur_op = eng_op;
          cur_wd = eng_wdata;
          op_log[n_log]  = eng_op;
          wd_log[n_log]  = eng_wdata;
          gap_log[n_log] = lowcnt;
          n_log++;
          if (cur_op == 2'd0) wcount = 0;
          else if (cur_op == 2'd1) wcount++;
          active   = 1'b1;
          wait_cnt = rand_dly ? int'($urandom_range(50, 0)) : fixed_dly;
          if (wait_cnt == 0) fire();
        end else begin
          if (eng_req !== 1'b1) lowcnt++;
          if (idle_spur_done < idle_spur_req && hold == 0 && eng_req !== 1'b1) begin
            eng_done = 1'b1;
            eng_nack = 1'b0;
            hold = 1;
            idle_spur_done++;
          end
        end
      end
    end
  end

  // Expected request sequence
  logic [1:0] exp_op [256];
  logic [7:0] exp_wd [256];
  int exp_n = 0;

  task automatic exp_push(input logic [1:0] op, input logic [7:0] wd);
    exp_op[exp_n] = op;
    exp_wd[exp_n] = wd;
    exp_n++;
  endtask

  // nack_at: 0 none, 1 address byte, 2 register byte, 3+k data byte k
  task automatic exp_attempt(input logic [6:0] dev, input logic [7:0] rg, input int len,
                             input logic [31:0] data, input int nack_at);
    logic [31:0] sh;
    exp_push(2'd0, 8'h00);
    exp_push(2'd1, {dev, 1'b0});
    if (nack_at == 1) begin exp_push(2'd2, 8'h00); return; end
    exp_push(2'd1, rg);
    if (nack_at == 2) begin exp_push(2'd2, 8'h00); return; end
    for (int k = 0; k <= len; k++) begin
      sh = data >> (8 * k);
      exp_push(2'd1, sh[7:0]);
      if (nack_at == 3 + k) begin exp_push(2'd2, 8'h00); return; end
    end
    exp_push(2'd2, 8'h00);
  endtask

  task automatic cmp_seq(input string tag, input int base);
    int got_n;
    got_n = n_log - base;
    check($sformatf("%s_nreq", tag), got_n, exp_n);
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      check($sformatf("%s_op%0d", tag, i), 32'(op_log[base + i]), 32'(exp_op[i]));
      if (exp_op[i] == 2'd1)
        check($sformatf("%s_wd%0d", tag, i), 32'(wd_log[base + i]), 32'(exp_wd[i]));
      if (i > 0) begin
        if (exp_op[i] == 2'd0) begin
          check($sformatf("%s_gapmin%0d", tag, i), 32'(gap_log[base + i] >= RG), 1);
          check($sformatf("%s_gapmax%0d", tag, i), 32'(gap_log[base + i] <= RG + 1), 1);
        end else begin
          check($sformatf("%s_gap%0d", tag, i), gap_log[base + i], 1);
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic [1:0] len,
                         input logic [31:0] data, output logic d_err, output logic [1:0] d_rc,
                         output int base);
    int bad;
    bit got;
    base  = n_log;
    d_err = 1'bx;
    d_rc  = 2'bxx;
    @(negedge clk);
    cmd_dev = dev; cmd_reg = rg; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    // keep offering a different command while busy; it must be ignored
    cmd_dev = 7'h7F; cmd_reg = 8'hEE; cmd_len = 2'd3; cmd_data = 32'hDEADBEEF;
    check("accept_busy", 32'(busy), 1);
    check("accept_ready", 32'(cmd_ready), 0);
    check("accept_rc_clr", 32'(retry_cnt), 0);
    check("accept_err_clr", 32'(error), 0);
    bad = 0;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        d_err = error;
        d_rc = retry_cnt;
        cmd_valid = 1'b0;
        if (busy !== 1'b1) bad++;
      end else if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
      end
    end
    cmd_valid = 1'b0;
    check("done_seen", 32'(got), 1);
    check("ready_low_during", bad, 0);
    @(negedge clk);
    check("ready_after", 32'(cmd_ready), 1);
    check("busy_after", 32'(busy), 0);
    check("done_pulse", 32'(done), 0);
  endtask

  logic       r_err;
  logic [1:0] r_rc;
  int         base;
  int         se0;
  bit         hit;

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_len = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_req", 32'(eng_req), 0);
    check("rst_op", 32'(eng_op), 0);
    check("rst_wdata", 32'(eng_wdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    reset = 1'b1;
    @(negedge clk);

    // Stray eng_done while idle
    idle_spur_req = 1;
    repeat (4) @(negedge clk);
    check("idle_spur_fired", idle_spur_done, 1);
    check("idle_spur_ready", 32'(cmd_ready), 1);
    check("idle_spur_busy", 32'(busy), 0);

    // Single byte
    fixed_dly = 2;
    run_cmd(7'h50, 8'h10, 2'd0, 32'h000000AB, r_err, r_rc, base);
    exp_n = 0;
    exp_attempt(7'h50, 8'h10, 0, 32'h000000AB, 0);
    cmp_seq("single", base);
    check("single_err", 32'(r_err), 0);
    check("single_rc", 32'(r_rc), 0);

    // Four bytes
    fixed_dly = 0;
    run_cmd(7'h50, 8'h10, 2'd3, 32'h44332211, r_err, r_rc, base);
    exp_n = 0;
    exp_attempt(7'h50, 8'h10, 3, 32'h44332211, 0);
    cmp_seq("four", base);
    check("four_err", 32'(r_err), 0);

    // One NACK on address, then successful retry
    fixed_dly = 1;
    nack_mode = 1;
    nack_cap  = nack_given + 1;
    run_cmd(7'h21, 8'h05, 2'd1, 32'h0000BEEF, r_err, r_rc, base);
    exp_n = 0;
    exp_attempt(7'h21, 8'h05, 1, 32'h0000BEEF, 1);
    exp_attempt(7'h21, 8'h05, 1, 32'h0000BEEF, 0);
    cmp_seq("nack_addr", base);
    check("nack_addr_err", 32'(r_err), 0);
    check("nack_addr_rc", 32'(r_rc), 1);

    // Persistent NACK on second data byte: all retries exhausted
    nack_mode = 2;
    run_cmd(7'h3C, 8'h20, 2'd2, 32'h00CCBBAA, r_err, r_rc, base);
    exp_n = 0;
    for (int a = 0; a < 4; a++) exp_attempt(7'h3C, 8'h20, 2, 32'h00CCBBAA, 4);
    cmp_seq("nack_data", base);
    check("nack_data_err", 32'(r_err), 1);
    check("nack_data_rc", 32'(r_rc), 3);
    repeat (30) @(negedge clk);
    check("no_extra_start", n_log - base, 24);
    check("err_hold", 32'(error), 1);
    check("rc_hold", 32'(retry_cnt), 3);
    nack_mode = 0;

    // Random engine latency with stray eng_done in the request gap
    rand_dly = 1'b1;
    spur_ext = 1'b1;
    se0 = stab_err;
    run_cmd(7'h11, 8'h99, 2'd2, 32'h00C3B2A1, r_err, r_rc, base);
    exp_n = 0;
    exp_attempt(7'h11, 8'h99, 2, 32'h00C3B2A1, 0);
    cmp_seq("hs", base);
    check("hs_stable", stab_err - se0, 0);
    check("hs_err", 32'(r_err), 0);
    check("hs_rc", 32'(r_rc), 0);
    rand_dly = 1'b0;
    spur_ext = 1'b0;

    // Reset in the middle of the DATA phase
    fixed_dly = 10;
    @(negedge clk);
    cmd_dev = 7'h12; cmd_reg = 8'h34; cmd_len = 2'd1; cmd_data = 32'h00005A5A; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (eng_req === 1'b1 && eng_op === 2'd1 && eng_wdata === 8'h5A) hit = 1'b1;
    end
    check("rst_mid_reached", 32'(hit), 1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_req", 32'(eng_req), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 1);
    check("post_rst_req", 32'(eng_req), 0);
    fixed_dly = 1;
    run_cmd(7'h50, 8'h10, 2'd0, 32'h000000AB, r_err, r_rc, base);
    exp_n = 0;
    exp_attempt(7'h50, 8'h10, 0, 32'h000000AB, 0);
    cmp_seq("post_rst", base);
    check("post_rst_err", 32'(r_err), 0);
    check("post_rst_rc", 32'(r_rc), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
